// File: rtl/par_to_serial_tx_pkg.sv
// rtl/par_to_serial_tx_pkg.sv - shared defaults and FSM encoding for the serialiser
package par_to_serial_tx_pkg;

  localparam logic [7:0] IDLE_SYM_DEF   = 8'hBC;
  localparam int         SYNC_COUNT_DEF = 4;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/par_to_serial_tx_sym_shift_reg.sv
// rtl/par_to_serial_tx_sym_shift_reg.sv - MSB-first symbol shifter with bit counter and boundary flag
module par_to_serial_tx_sym_shift_reg
  import par_to_serial_tx_pkg::*;
#(
  parameter int              SIZE     = 8,
  parameter logic [SIZE-1:0] IDLE_SYM = IDLE_SYM_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] next_sym,
  input  logic            next_active,
  output logic            boundary,
  output logic            ser_bit,
  output logic            sym_start,
  output logic            active
);

  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;

  logic [SIZE-1:0] sr;
  logic            sr_active;
  logic [CW-1:0]   bit_cnt;

  assign boundary = (bit_cnt == CW'(SIZE - 1));

  // Line outputs are registered from the pre-shift state, so they lag the shifter by one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr        <= IDLE_SYM;
      sr_active <= 1'b0;
      bit_cnt   <= '0;
      ser_bit   <= 1'b0;
      sym_start <= 1'b0;
      active    <= 1'b0;
    end else begin
      ser_bit   <= sr[SIZE-1];
      sym_start <= (bit_cnt == '0);
      active    <= sr_active;
      if (boundary) begin
        sr        <= next_sym;
        sr_active <= next_active;
        bit_cnt   <= '0;
      end else begin
        sr        <= {sr[SIZE-2:0], 1'b0};
        bit_cnt   <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/par_to_serial_tx.sv
// rtl/par_to_serial_tx.sv - byte-to-serial transmitter with sync preamble and idle insertion
module par_to_serial_tx
  import par_to_serial_tx_pkg::*;
#(
  parameter int              SIZE       = 8,
  parameter logic [SIZE-1:0] IDLE_SYM   = IDLE_SYM_DEF,
  parameter int              SYNC_COUNT = SYNC_COUNT_DEF
) (
  input  logic            BIT_RATE_CLK,
  input  logic            RESET,
  input  logic [SIZE-1:0] DATA_IN,
  input  logic            VALID_IN,
  output logic            READY_OUT,
  output logic            DATA_OUT,
  output logic            SYM_START,
  output logic            ACTIVE
);

  localparam int              SW        = $clog2(SYNC_COUNT + 1);
  localparam logic [SW-1:0]   SYNC_LAST = SW'(SYNC_COUNT - 1);

  state_t          state, state_next;
  logic [SW-1:0]   sync_cnt;
  logic [SIZE-1:0] buf_data;
  logic            buf_full;
  logic            boundary;
  logic            xfer;
  logic [SIZE-1:0] next_sym;
  logic            next_active;

  assign xfer = VALID_IN && READY_OUT;

  always_ff @(posedge BIT_RATE_CLK or negedge RESET) begin
    if (!RESET) state <= SYNC;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    READY_OUT  = 1'b0;
    case (state)
      SYNC: if (boundary && sync_cnt == SYNC_LAST) state_next = RUN;
      RUN:  READY_OUT = !buf_full;
    endcase
  end

  always_ff @(posedge BIT_RATE_CLK or negedge RESET) begin
    if (!RESET)                         sync_cnt <= '0;
    else if (state == SYNC && boundary) sync_cnt <= sync_cnt + 1'b1;
  end

  // A byte taken on a boundary edge with the buffer empty bypasses straight into the shifter.
  always_comb begin
    next_sym    = IDLE_SYM;
    next_active = 1'b0;
    if (buf_full) begin
      next_sym    = buf_data;
      next_active = 1'b1;
    end else if (xfer) begin
      next_sym    = DATA_IN;
      next_active = 1'b1;
    end
  end

  always_ff @(posedge BIT_RATE_CLK or negedge RESET) begin
    if (!RESET) begin
      buf_data <= '0;
      buf_full <= 1'b0;
    end else if (boundary) begin
      buf_full <= 1'b0;
    end else if (xfer) begin
      buf_data <= DATA_IN;
      buf_full <= 1'b1;
    end
  end

  par_to_serial_tx_sym_shift_reg #(
    .SIZE     (SIZE),
    .IDLE_SYM (IDLE_SYM)
  ) u_shift (
    .clk         (BIT_RATE_CLK),
    .rst_n       (RESET),
    .next_sym    (next_sym),
    .next_active (next_active),
    .boundary    (boundary),
    .ser_bit     (DATA_OUT),
    .sym_start   (SYM_START),
    .active      (ACTIVE)
  );

endmodule

// File: tb/tb_par_to_serial_tx.sv
// tb/tb_par_to_serial_tx.sv - self-checking bench for par_to_serial_tx against a slot-schedule model
module tb_par_to_serial_tx;

  localparam int         SIZE = 8;
  localparam int         SYNC = 4;
  localparam logic [7:0] IDLE = 8'hBC;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out, data_out, sym_start, active;

  int checks = 0;
  int failures = 0;

  // Model: edges since reset release, the symbol chosen for every slot, and one pending byte.
  int         edges;
  logic [8:0] sched[$];
  logic       pend_v;
  logic [7:0] pend;
  int         act_cnt;

  always #5 clk = ~clk;

  par_to_serial_tx #(.SIZE(SIZE), .IDLE_SYM(IDLE), .SYNC_COUNT(SYNC)) dut (
    .BIT_RATE_CLK (clk),
    .RESET        (rst_n),
    .DATA_IN      (data_in),
    .VALID_IN     (valid_in),
    .READY_OUT    (ready_out),
    .DATA_OUT     (data_out),
    .SYM_START    (sym_start),
    .ACTIVE       (active)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h edge=%0d", tag, obs, exp, edges);
    end
  endtask

  function automatic logic exp_ready();
    return (edges >= SIZE * SYNC) && !pend_v;
  endfunction

  task automatic model_reset();
    edges  = 0;
    pend_v = 1'b0;
    pend   = '0;
    sched.delete();
    sched.push_back({1'b0, IDLE});
  endtask

  task automatic model_edge(input logic v, input logic [7:0] d);
    if (v && exp_ready()) begin
      pend_v = 1'b1;
      pend   = d;
    end
    edges++;
    if (edges % SIZE == 0) begin
      sched.push_back(pend_v ? {1'b1, pend} : {1'b0, IDLE});
      pend_v = 1'b0;
    end
  endtask

  // One bit period: drive after the falling edge, check READY, step the model, check the line.
  task automatic cycle(input logic v, input logic [7:0] d);
    logic [8:0] s;
    int         i;
    valid_in = v;
    data_in  = d;
    #1;
    chk("ready_out", ready_out, exp_ready());
    model_edge(v, d);
    @(posedge clk);
    @(negedge clk);
    s = sched[(edges - 1) / SIZE];
    i = (edges - 1) % SIZE;
    chk("data_out", data_out, s[7 - i]);
    chk("sym_start", sym_start, i == 0);
    chk("active", active, s[8]);
    if (active === 1'b1) act_cnt++;
  endtask

  task automatic wait_phase(input int p);
    for (int k = 0; k < 2 * SIZE && (edges % SIZE) != p; k++) cycle(1'b0, 8'h00);
    chk("phase_reached", edges % SIZE, p);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    valid_in = 1'b0;
    #1;
    chk("rst_data_out", data_out, 1'b0);
    chk("rst_sym_start", sym_start, 1'b0);
    chk("rst_active", active, 1'b0);
    chk("rst_ready", ready_out, 1'b0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] b2b[3];
    int         idx;
    rst_n    = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    b2b[0] = 8'h01; b2b[1] = 8'h02; b2b[2] = 8'hFF;

    // Reset, then 64 idle cycles: four sync symbols then READY rises.
    apply_reset();
    for (int k = 0; k < 64; k++) cycle(1'b0, 8'h00);

    // A5 offered mid-symbol.
    wait_phase(3);
    cycle(1'b1, 8'hA5);
    chk("a5_buffered_ready", ready_out, 1'b0);
    for (int k = 0; k < 20; k++) cycle(1'b0, 8'h00);

    // Back-to-back bytes with VALID held.
    idx = 0;
    for (int k = 0; k < 64 && idx < 3; k++) begin
      logic r;
      #1;
      r = ready_out;
      cycle(1'b1, b2b[idx]);
      if (r) idx++;
    end
    chk("b2b_all_accepted", idx, 3);
    for (int k = 0; k < 24; k++) cycle(1'b0, 8'h00);

    // Bypass on a boundary edge.
    wait_phase(7);
    cycle(1'b1, 8'h3C);
    cycle(1'b0, 8'h00);
    chk("bypass_sym_start", sym_start, 1'b1);
    chk("bypass_active", active, 1'b1);
    for (int k = 0; k < 12; k++) cycle(1'b0, 8'h00);

    // Data byte equal to the idle symbol.
    wait_phase(2);
    cycle(1'b1, IDLE);
    for (int k = 0; k < 20; k++) cycle(1'b0, 8'h00);

    // Reset mid-data-symbol with 77 buffered.
    wait_phase(7);
    cycle(1'b1, 8'h55);
    cycle(1'b0, 8'h00);
    cycle(1'b1, 8'h77);
    cycle(1'b0, 8'h00);
    chk("pre_reset_active", active, 1'b1);
    apply_reset();
    act_cnt = 0;
    for (int k = 0; k < 48; k++) cycle(1'b0, 8'h00);
    chk("no_77_after_reset", act_cnt, 0);

    // Randomised traffic.
    for (int k = 0; k < 600; k++) cycle(1'($urandom_range(0, 1)), 8'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/par_to_serial_tx.md
Name: par_to_serial_tx

Overview:
- Serialiser stage directly downstream of the size converter.
- Accepts one SIZE-bit byte per handshake from the converter's byte output.
- Shifts bytes out MSB-first, one bit per BIT_RATE_CLK.
- Inserts the idle/COM symbol (0xBC) on every symbol slot with no data, so the line never stalls.
- After reset, it emits a fixed number of sync symbols before it accepts any data.

Parameters:
- SIZE, 8, symbol width in bits.
- IDLE_SYM, 8'hBC, symbol sent when no data is buffered (K28.5 COM).
- SYNC_COUNT, 4, number of complete idle symbols sent after reset before READY_OUT may assert.

Ports:
- BIT_RATE_CLK  input  1  bit-rate clock; the only clock in the block.
- RESET  input  1  asynchronous, active-low reset (0 = reset).
- DATA_IN  input  SIZE  byte from the size converter.
- VALID_IN  input  1  DATA_IN holds a valid byte.
- READY_OUT  output  1  block can accept a byte this cycle.
- DATA_OUT  output  1  serial line, registered.
- SYM_START  output  1  one-cycle pulse when DATA_OUT carries bit 0 (MSB) of a symbol.
- ACTIVE  output  1  high for every bit of a data symbol; low for idle symbols.

Behaviour:
- Reset (RESET=0, asynchronous):
  - DATA_OUT=0, SYM_START=0, ACTIVE=0, READY_OUT=0.
  - Shift register=IDLE_SYM, bit counter=0, sync counter=0, holding buffer empty, state=SYNC.
- Bit timing:
  - Each rising edge drives the current shift-register MSB onto DATA_OUT.
  - The shift register then shifts left by 1 and the bit counter increments (0..SIZE-1, wraps to 0).
  - Symbol n, bit i is on DATA_OUT during cycle SIZE*n+i+1 after reset release.
  - SYM_START=1 exactly on the cycles where bit counter was 0 at the edge.
- Symbol boundary (edge where bit counter == SIZE-1): the shift register reloads with the next symbol.
  - Next symbol is the holding buffer if full (buffer is then emptied), else IDLE_SYM.
  - ACTIVE for the next symbol = 1 if loaded from data, 0 if IDLE_SYM; it is registered alongside SYM_START.
- States:
  - SYNC:
    - READY_OUT=0; only IDLE_SYM symbols are sent.
    - The sync counter increments at each boundary.
    - Moves to RUN at the boundary that completes symbol SYNC_COUNT.
  - RUN:
    - READY_OUT = !buffer_full (combinational).
    - No return to SYNC except through reset.
- Handshake:
  - A transfer occurs on an edge with VALID_IN && READY_OUT.
  - The byte is written to the one-entry holding buffer.
  - Buffer full -> READY_OUT=0 until the boundary that drains it.
- Bypass: if a transfer happens on a boundary edge with the buffer empty, the byte loads straight into the shift register.
  - No intervening idle symbol is sent; the buffer stays empty.
- Boundary with buffer full: the buffer drains into the shift register.
  - READY_OUT is 0 on that edge, so no simultaneous write occurs.
- Latency: a byte accepted with the buffer empty starts transmitting at the next symbol boundary.
  - Latency is 1..SIZE cycles to SYM_START.
- A data byte equal to IDLE_SYM is sent as data with ACTIVE=1; the receiver distinguishes it only via framing, not here.
- VALID_IN while READY_OUT=0: the byte is ignored; the upstream holds it.
- Reset mid-symbol or mid-buffer: the partial symbol and buffered byte are discarded; the sync sequence restarts.
- Width: bit counter is clog2(SIZE) bits; sync counter is clog2(SYNC_COUNT+1) bits; no other arithmetic.

Decomposition:
- Shared package/include holds: IDLE_SYM default (8'hBC), state encodings SYNC=1'b0 and RUN=1'b1, and the SYNC_COUNT default.
- One natural sub-module: sym_shift_reg. It holds the SIZE-bit parallel-load shift register plus the bit counter and boundary flag.
- The top level holds the FSM, holding buffer and handshake.

Test Plan:
1. Reset, then VALID_IN=0 for 64 cycles:
   - DATA_OUT repeats 10111100 every 8 cycles with SYM_START every 8th cycle and ACTIVE=0.
   - READY_OUT rises only after 32 cycles (4 symbols).
2. After sync, present 8'hA5 mid-symbol:
   - Accepted in one cycle, READY_OUT=0 until the next boundary.
   - The next symbol is 10100101 with ACTIVE=1 for those 8 cycles, then idle resumes.
3. Back-to-back bytes 8'h01, 8'h02, 8'hFF with VALID_IN held:
   - Three contiguous data symbols with no idle between them.
   - READY_OUT pulses once per symbol.
4. Offer 8'h3C exactly on a boundary edge with the buffer empty:
   - Bypass; 00111100 starts at the very next cycle with SYM_START=1.
5. Send data 8'hBC:
   - Line pattern is identical to idle but ACTIVE=1 for those 8 cycles.
6. Assert RESET=0 mid-data-symbol with 8'h77 buffered:
   - Outputs clear immediately; after release, 4 idle symbols are sent and 8'h77 is never transmitted.
